// File: rtl/mul_div_pkg.sv
// Widths and FSM encoding shared by the bit-serial divider and the shift-add multiplier.
package mul_div_pkg;
  localparam int A_W = 8;          // quotient / multiplier width
  localparam int B_W = 12;         // divisor / multiplicand width
  localparam int P_W = A_W + B_W;  // dividend / product width

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_MUL  = 2'd2,
    ST_DONE = 2'd3
  } state_t;
endpackage

// File: rtl/shift_add_multiplier.sv
// Unsigned shift-add multiplier, one multiplier bit per cycle with early exit once the remaining bits are zero.
// Result pulses 1..A_W cycles after in_valid falls; in_valid is ignored while busy, so there is no backpressure.
module shift_add_multiplier
  import mul_div_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  input  logic [A_W-1:0] in_data_1,
  input  logic [B_W-1:0] in_data_2,
  output logic           out_valid,
  output logic [P_W-1:0] out_data
);

  state_t         state;
  state_t         next_state;
  logic [A_W-1:0] a_reg;
  logic [B_W-1:0] b_reg;
  logic [A_W-1:0] mplier;
  logic [P_W-1:0] mcand;
  logic [P_W-1:0] acc;
  logic [P_W-1:0] acc_sum;
  logic           mul_last;

  // The current bit is the last useful one when nothing above it is set.
  assign mul_last = (mplier[A_W-1:1] == '0);
  assign acc_sum  = acc + (mplier[0] ? mcand : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = ST_IDLE;
    case (state)
      ST_IDLE: next_state = in_valid ? ST_LOAD : ST_IDLE;
      ST_LOAD: next_state = in_valid ? ST_LOAD : ST_MUL;
      ST_MUL:  next_state = mul_last ? ST_DONE : ST_MUL;
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      mplier    <= '0;
      mcand     <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_reg <= in_data_1;
            b_reg <= in_data_2;
          end
        end
        ST_LOAD: begin
          // Last operand seen while in_valid is held wins.
          if (in_valid) begin
            a_reg <= in_data_1;
            b_reg <= in_data_2;
          end else begin
            acc    <= '0;
            mplier <= a_reg;
            mcand  <= {{A_W{1'b0}}, b_reg};
          end
        end
        ST_MUL: begin
          acc    <= acc_sum;
          mplier <= mplier >> 1;
          mcand  <= mcand << 1;
          if (mul_last) begin
            out_data  <= acc_sum;
            out_valid <= 1'b1;
          end
        end
        ST_DONE: begin
          out_valid <= 1'b0;
          out_data  <= '0;
        end
        default: begin
          out_valid <= 1'b0;
          out_data  <= '0;
        end
      endcase
    end
  end

endmodule
